segre_pipeline_ctrl: RTL and testbench
======================================

// Module: segre_pipeline_ctrl
// PURPOSE
// Pipeline sequencer for the 5-stage Segre core (IF, ID, EX, MEM, WB). Detects RAW hazards
// (no forwarding), data-memory waits, taken branches and end-of-test. Drives per-stage
// block/inject_nops controls to the stage decoupling registers.
// Tracks memory-wait timeout and test drain/halt in a small FSM.
// PARAMETERS
// REG_SIZE      5   register-file address width
// DRAIN_CYCLES  3   cycles to drain EX/MEM/WB after finish is seen in ID
// MEM_TIMEOUT   64  max consecutive mem_busy_i cycles before mem_timeout_o
// PORTS
// clk_i              in   1         clock
// rsn_i              in   1         reset, synchronous, active-low
// id_valid_i         in   1         ID holds valid instr
// id_src_a_i         in   REG_SIZE  ID rs1 identifier
// id_src_b_i         in   REG_SIZE  ID rs2 identifier
// ex_valid_i         in   1         EX holds valid instr
// ex_rf_we_i         in   1         EX instr writes RF
// ex_rf_waddr_i      in   REG_SIZE  EX destination
// mem_valid_i        in   1         MEM holds valid instr
// mem_rf_we_i        in   1         MEM instr writes RF
// mem_rf_waddr_i     in   REG_SIZE  MEM destination
// br_taken_i         in   1         EX resolved taken branch/jump
// mem_busy_i         in   1         data memory not ready this cycle
// finish_test_i      in   1         finish instr valid in ID
// block_if_o         out  1         hold PC/IF register
// block_id_o         out  1         hold IF/ID register
// block_ex_o         out  1         hold ID/EX register
// block_mem_o        out  1         hold EX/MEM register
// inject_nops_id_o   out  1         load NOP into IF/ID register
// inject_nops_ex_o   out  1         load NOP into ID/EX register
// mem_timeout_o      out  1         sticky: memory wait exceeded MEM_TIMEOUT
// halted_o           out  1         core drained and halted
// BEHAVIOUR
// - FSM states: RUN, MEM_WAIT, DRAIN, HALT. Reset (rsn_i=0 at posedge) -> RUN.
//   Counters cleared, mem_timeout_o=0.
// - While rsn_i=0: all block_*=0, inject_nops_*=1, halted_o=0, mem_timeout_o=0.
// - Outputs are combinational from state and inputs; state and counters are registered.
// - raw = id_valid_i & any(src!=0 & src==X_waddr & X_we & X_valid) for src in {a,b},
//   X in {ex,mem}. RF is write-through, so WB never conflicts.
// - Priority within RUN/MEM_WAIT: mem_busy > br_taken > raw.
// - mem_busy_i=1: all block_*=1, inject_*=0. Next state MEM_WAIT.
//   wait_cnt increments each busy cycle. If wait_cnt reaches MEM_TIMEOUT-1 while busy,
//   mem_timeout_o sets (sticky until reset).
//   mem_busy_i=0 in MEM_WAIT -> RUN, wait_cnt=0. That cycle is evaluated as RUN.
// - br_taken_i & ex_valid_i: inject_nops_id_o=1, inject_nops_ex_o=1, blocks=0.
//   Squashes IF and ID. A concurrent raw is ignored.
// - raw, no branch: block_if_o=block_id_o=1, inject_nops_ex_o=1 (bubble).
//   Repeats each cycle until raw clears: 1 bubble if MEM only, 2 if EX.
// - finish_test_i in RUN with no mem_busy/branch/raw -> DRAIN, drain_cnt=0.
//   In DRAIN: block_if=block_id=1, inject_nops_ex=1. Later stages advance;
//   mem_busy still freezes everything and pauses drain_cnt.
//   drain_cnt==DRAIN_CYCLES-1 -> HALT.
// - finish_test_i coinciding with br_taken: branch wins, finish is squashed, no DRAIN.
// - HALT: all block_*=1, halted_o=1. Exited only by reset.
// - Counters saturate; no wrap. Reset mid-MEM_WAIT/DRAIN aborts to RUN next cycle.
// CONFIGURATION
// - SEGRE_CTRL_PERF_EN defined: adds outputs stall_cycles_o[31:0] and flush_cnt_o[31:0].
//   stall_cycles_o counts raw and mem_busy cycles; flush_cnt_o counts taken-branch squashes.
//   Both saturate at 32'hffffffff and reset to 0.
// - Undefined: those ports and counters do not exist; behaviour is otherwise identical.
// TESTING
// - RAW in EX: ID src_a=5, EX we=1 waddr=5 -> 2 cycles block_if/id=1, inject_ex=1, then flow.
// - x0 source: src_a=0, EX waddr=0 we=1 -> no stall.
// - Branch + raw same cycle: br_taken=1, raw=1 -> inject_id=inject_ex=1, block_*=0.
// - mem_busy 3 cycles, MEM_TIMEOUT=4 -> all blocks 3 cycles, no timeout.
//   Busy 4 cycles -> mem_timeout_o=1, sticky.
// - finish in ID, mem_busy 1 cycle during DRAIN -> halted_o rises after DRAIN_CYCLES+1 cycles
//   and stays; reset returns to RUN with halted_o=0.
// - PERF_EN: 2 raw + 1 busy + 1 branch -> stall_cycles_o=3, flush_cnt_o=1.

Source files
------------

// File: rtl/segre_pipeline_ctrl.sv
// Pipeline sequencer for the 5-stage Segre core: RAW/branch/memory-wait hazard control plus drain/halt FSM.
// Optional macro SEGRE_CTRL_PERF_EN adds stall_cycles_o and flush_cnt_o performance counters.
module segre_pipeline_ctrl #(
   parameter int REG_SIZE     = 5,
   parameter int DRAIN_CYCLES = 3,
   parameter int MEM_TIMEOUT  = 64
) (
   input  logic                clk_i,
   input  logic                rsn_i,
   input  logic                id_valid_i,
   input  logic [REG_SIZE-1:0] id_src_a_i,
   input  logic [REG_SIZE-1:0] id_src_b_i,
   input  logic                ex_valid_i,
   input  logic                ex_rf_we_i,
   input  logic [REG_SIZE-1:0] ex_rf_waddr_i,
   input  logic                mem_valid_i,
   input  logic                mem_rf_we_i,
   input  logic [REG_SIZE-1:0] mem_rf_waddr_i,
   input  logic                br_taken_i,
   input  logic                mem_busy_i,
   input  logic                finish_test_i,
   output logic                block_if_o,
   output logic                block_id_o,
   output logic                block_ex_o,
   output logic                block_mem_o,
   output logic                inject_nops_id_o,
   output logic                inject_nops_ex_o,
   output logic                mem_timeout_o,
   output logic                halted_o
`ifdef SEGRE_CTRL_PERF_EN
   ,
   output logic [31:0]         stall_cycles_o,
   output logic [31:0]         flush_cnt_o
`endif
);

   localparam int WAIT_W  = $clog2(MEM_TIMEOUT + 1);
   localparam int DRAIN_W = $clog2(DRAIN_CYCLES + 1);

   typedef enum logic [1:0] {ST_RUN, ST_MEM_WAIT, ST_DRAIN, ST_HALT} state_t;

   state_t              state_q, state_d;
   logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
   logic [DRAIN_W-1:0]  drain_cnt_q, drain_cnt_d;
   logic                timeout_q, timeout_d;
   logic                raw;
   logic                stall_evt, flush_evt;
   logic                blk_if, blk_id, blk_ex, blk_mem, inj_id, inj_ex;

   // A source matches only a valid, writing producer; x0 never creates a dependency.
   function automatic logic src_hit(input logic [REG_SIZE-1:0] src,
                                    input logic                vld,
                                    input logic                we,
                                    input logic [REG_SIZE-1:0] waddr);
      return vld & we & (src != '0) & (src == waddr);
   endfunction

   always_comb begin
      raw = id_valid_i &
            (src_hit(id_src_a_i, ex_valid_i,  ex_rf_we_i,  ex_rf_waddr_i)  |
             src_hit(id_src_a_i, mem_valid_i, mem_rf_we_i, mem_rf_waddr_i) |
             src_hit(id_src_b_i, ex_valid_i,  ex_rf_we_i,  ex_rf_waddr_i)  |
             src_hit(id_src_b_i, mem_valid_i, mem_rf_we_i, mem_rf_waddr_i));
   end

   always_comb begin
      state_d     = state_q;
      drain_cnt_d = drain_cnt_q;
      wait_cnt_d  = '0;
      if (mem_busy_i)
         wait_cnt_d = (wait_cnt_q == '1) ? wait_cnt_q : wait_cnt_q + WAIT_W'(1);
      timeout_d   = timeout_q | (mem_busy_i & (wait_cnt_q >= WAIT_W'(MEM_TIMEOUT - 1)));
      blk_if      = 1'b0;
      blk_id      = 1'b0;
      blk_ex      = 1'b0;
      blk_mem     = 1'b0;
      inj_id      = 1'b0;
      inj_ex      = 1'b0;
      stall_evt   = 1'b0;
      flush_evt   = 1'b0;

      case (state_q)
         ST_RUN, ST_MEM_WAIT: begin
            if (mem_busy_i) begin
               {blk_if, blk_id, blk_ex, blk_mem} = 4'hf;
               stall_evt = 1'b1;
               state_d   = ST_MEM_WAIT;
            end else begin
               // Leaving MEM_WAIT, this cycle is judged exactly like RUN.
               state_d = ST_RUN;
               if (br_taken_i && ex_valid_i) begin
                  inj_id    = 1'b1;
                  inj_ex    = 1'b1;
                  flush_evt = 1'b1;
               end else if (raw) begin
                  blk_if    = 1'b1;
                  blk_id    = 1'b1;
                  inj_ex    = 1'b1;
                  stall_evt = 1'b1;
               end else if (finish_test_i) begin
                  state_d     = ST_DRAIN;
                  drain_cnt_d = '0;
               end
            end
         end
         ST_DRAIN: begin
            if (mem_busy_i) begin
               {blk_if, blk_id, blk_ex, blk_mem} = 4'hf;
               stall_evt = 1'b1;
            end else begin
               blk_if = 1'b1;
               blk_id = 1'b1;
               inj_ex = 1'b1;
               if (drain_cnt_q >= DRAIN_W'(DRAIN_CYCLES - 1))
                  state_d = ST_HALT;
               else
                  drain_cnt_d = drain_cnt_q + DRAIN_W'(1);
            end
         end
         ST_HALT: begin
            {blk_if, blk_id, blk_ex, blk_mem} = 4'hf;
         end
         default: state_d = ST_RUN;
      endcase
   end

   // During reset the stages flow freely while NOPs are loaded into IF/ID and ID/EX.
   always_comb begin
      block_if_o       = rsn_i & blk_if;
      block_id_o       = rsn_i & blk_id;
      block_ex_o       = rsn_i & blk_ex;
      block_mem_o      = rsn_i & blk_mem;
      inject_nops_id_o = ~rsn_i | inj_id;
      inject_nops_ex_o = ~rsn_i | inj_ex;
      mem_timeout_o    = rsn_i & timeout_q;
      halted_o         = rsn_i & (state_q == ST_HALT);
   end

   always_ff @(posedge clk_i) begin
      if (!rsn_i) begin
         state_q     <= ST_RUN;
         wait_cnt_q  <= '0;
         drain_cnt_q <= '0;
         timeout_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         wait_cnt_q  <= wait_cnt_d;
         drain_cnt_q <= drain_cnt_d;
         timeout_q   <= timeout_d;
      end
   end

`ifdef SEGRE_CTRL_PERF_EN
   logic [31:0] stall_cycles_q, stall_cycles_d;
   logic [31:0] flush_cnt_q, flush_cnt_d;

   always_comb begin
      stall_cycles_d = stall_cycles_q;
      flush_cnt_d    = flush_cnt_q;
      if (stall_evt && (stall_cycles_q != 32'hffffffff))
         stall_cycles_d = stall_cycles_q + 32'd1;
      if (flush_evt && (flush_cnt_q != 32'hffffffff))
         flush_cnt_d = flush_cnt_q + 32'd1;
   end

   always_ff @(posedge clk_i) begin
      if (!rsn_i) begin
         stall_cycles_q <= '0;
         flush_cnt_q    <= '0;
      end else begin
         stall_cycles_q <= stall_cycles_d;
         flush_cnt_q    <= flush_cnt_d;
      end
   end

   assign stall_cycles_o = stall_cycles_q;
   assign flush_cnt_o    = flush_cnt_q;
`else
   logic unused_perf;
   assign unused_perf = stall_evt ^ flush_evt;
`endif

endmodule

// File: tb/tb_segre_pipeline_ctrl.sv
// Scoreboard bench for segre_pipeline_ctrl: directed hazard scenarios followed by random traffic.
module tb_segre_pipeline_ctrl;

   localparam int RS    = 5;
   localparam int DRAIN = 3;
   localparam int MTO   = 4;

   logic          clk = 1'b0;
   logic          rsn_i, id_valid_i, ex_valid_i, ex_rf_we_i, mem_valid_i, mem_rf_we_i;
   logic [RS-1:0] id_src_a_i, id_src_b_i, ex_rf_waddr_i, mem_rf_waddr_i;
   logic          br_taken_i, mem_busy_i, finish_test_i;
   logic          block_if_o, block_id_o, block_ex_o, block_mem_o;
   logic          inject_nops_id_o, inject_nops_ex_o, mem_timeout_o, halted_o;
`ifdef SEGRE_CTRL_PERF_EN
   logic [31:0]   stall_cycles_o, flush_cnt_o;
`endif

   always #5 clk = ~clk;

   segre_pipeline_ctrl #(.REG_SIZE(RS), .DRAIN_CYCLES(DRAIN), .MEM_TIMEOUT(MTO)) dut (
      .clk_i(clk), .rsn_i(rsn_i), .id_valid_i(id_valid_i),
      .id_src_a_i(id_src_a_i), .id_src_b_i(id_src_b_i),
      .ex_valid_i(ex_valid_i), .ex_rf_we_i(ex_rf_we_i), .ex_rf_waddr_i(ex_rf_waddr_i),
      .mem_valid_i(mem_valid_i), .mem_rf_we_i(mem_rf_we_i), .mem_rf_waddr_i(mem_rf_waddr_i),
      .br_taken_i(br_taken_i), .mem_busy_i(mem_busy_i), .finish_test_i(finish_test_i),
      .block_if_o(block_if_o), .block_id_o(block_id_o), .block_ex_o(block_ex_o),
      .block_mem_o(block_mem_o), .inject_nops_id_o(inject_nops_id_o),
      .inject_nops_ex_o(inject_nops_ex_o), .mem_timeout_o(mem_timeout_o), .halted_o(halted_o)
`ifdef SEGRE_CTRL_PERF_EN
      , .stall_cycles_o(stall_cycles_o), .flush_cnt_o(flush_cnt_o)
`endif
   );

   typedef struct packed {
      logic          rsn, idv;
      logic [RS-1:0] sa, sb;
      logic          exv, exwe;
      logic [RS-1:0] exwa;
      logic          memv, memwe;
      logic [RS-1:0] memwa;
      logic          br, busy, fin;
   } stim_t;

   stim_t      s;
   logic [7:0] exp_q[$];
   int         errors = 0;
   int         checks = 0;
   int         cyc    = 0;

   // Reference model: pipeline "situation" as plain flags and counters.
   bit         m_halted, m_draining, m_timeout;
   int         m_drain_left, m_busy_run;
   longint     m_stall, m_flush;

   task automatic model_reset();
      m_halted = 0; m_draining = 0; m_timeout = 0;
      m_drain_left = 0; m_busy_run = 0; m_stall = 0; m_flush = 0;
   endtask

   function automatic bit depends(input logic [RS-1:0] src);
      return (src != 0) && ((s.exv && s.exwe && src == s.exwa) ||
                            (s.memv && s.memwe && src == s.memwa));
   endfunction

   // Expected vector: {blk_if, blk_id, blk_ex, blk_mem, inj_id, inj_ex, timeout, halted}
   task automatic model_cycle();
      logic [7:0] e;
      bit raw;
      raw = s.idv && (depends(s.sa) || depends(s.sb));
      if (!s.rsn) begin
         e = 8'b0000_1100;
         model_reset();
      end else begin
         e = 8'b0;
         e[1] = m_timeout;
         if (s.busy) begin
            m_busy_run++;
            if (m_busy_run >= MTO) m_timeout = 1;
         end else begin
            m_busy_run = 0;
         end
         if (m_halted) begin
            e[7:4] = 4'hf; e[0] = 1'b1;
         end else if (s.busy) begin
            e[7:4] = 4'hf; m_stall++;
         end else if (m_draining) begin
            e[7] = 1'b1; e[6] = 1'b1; e[2] = 1'b1;
            m_drain_left--;
            if (m_drain_left == 0) begin
               m_halted = 1; m_draining = 0;
            end
         end else if (s.br && s.exv) begin
            e[3] = 1'b1; e[2] = 1'b1; m_flush++;
         end else if (raw) begin
            e[7] = 1'b1; e[6] = 1'b1; e[2] = 1'b1; m_stall++;
         end else if (s.fin) begin
            m_draining = 1; m_drain_left = DRAIN;
         end
      end
      exp_q.push_back(e);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      rsn_i = s.rsn; id_valid_i = s.idv; id_src_a_i = s.sa; id_src_b_i = s.sb;
      ex_valid_i = s.exv; ex_rf_we_i = s.exwe; ex_rf_waddr_i = s.exwa;
      mem_valid_i = s.memv; mem_rf_we_i = s.memwe; mem_rf_waddr_i = s.memwa;
      br_taken_i = s.br; mem_busy_i = s.busy; finish_test_i = s.fin;
      model_cycle();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         s = '0; s.rsn = 1'b1; step();
      end
   endtask

   // Monitor: every cycle the DUT presents its control vector; compare against the queue head.
   initial begin
      logic [7:0] act, e;
      forever begin
         @(negedge clk);
         cyc++;
         if (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            act = {block_if_o, block_id_o, block_ex_o, block_mem_o,
                   inject_nops_id_o, inject_nops_ex_o, mem_timeout_o, halted_o};
            checks++;
            if (act !== e) begin
               errors++;
               $display("FAIL ctrl_vec cycle=%0d got=%b want=%b (if,id,ex,mem,injid,injex,tmo,halt)",
                        cyc, act, e);
            end
         end
      end
   end

   initial begin
      s = '0;
      rsn_i = 0; id_valid_i = 0; id_src_a_i = 0; id_src_b_i = 0; ex_valid_i = 0;
      ex_rf_we_i = 0; ex_rf_waddr_i = 0; mem_valid_i = 0; mem_rf_we_i = 0;
      mem_rf_waddr_i = 0; br_taken_i = 0; mem_busy_i = 0; finish_test_i = 0;
      model_reset();

      // Reset state
      s = '0; step(); step();
      idle(2);

      // RAW against EX, then against MEM, then clear
      s = '0; s.rsn = 1; s.idv = 1; s.sa = 5; s.exv = 1; s.exwe = 1; s.exwa = 5; step();
      s = '0; s.rsn = 1; s.idv = 1; s.sa = 5; s.memv = 1; s.memwe = 1; s.memwa = 5; step();
      s = '0; s.rsn = 1; s.idv = 1; s.sa = 5; step();

      // x0 source never stalls
      s = '0; s.rsn = 1; s.idv = 1; s.sa = 0; s.exv = 1; s.exwe = 1; s.exwa = 0; step();
      // RAW on rs2 against MEM
      s = '0; s.rsn = 1; s.idv = 1; s.sb = 7; s.memv = 1; s.memwe = 1; s.memwa = 7; step();

      // Branch and raw together: branch wins
      s = '0; s.rsn = 1; s.idv = 1; s.sa = 5; s.exv = 1; s.exwe = 1; s.exwa = 5; s.br = 1; step();
      idle(1);

      // 3 busy cycles: no timeout; 4 busy cycles: sticky timeout
      for (int i = 0; i < 3; i++) begin s = '0; s.rsn = 1; s.busy = 1; step(); end
      idle(2);
      for (int i = 0; i < 4; i++) begin s = '0; s.rsn = 1; s.busy = 1; step(); end
      idle(3);
      s = '0; step();
      idle(1);

      // Finish, one busy cycle during drain, halt, then reset back to RUN
      s = '0; s.rsn = 1; s.fin = 1; step();
      idle(1);
      s = '0; s.rsn = 1; s.busy = 1; step();
      idle(5);
      s = '0; step();
      idle(2);

      // Finish coinciding with a taken branch is squashed
      s = '0; s.rsn = 1; s.fin = 1; s.br = 1; s.exv = 1; step();
      idle(5);

      // Reset in the middle of a drain
      s = '0; s.rsn = 1; s.fin = 1; step();
      idle(1);
      s = '0; step();
      idle(2);

      // Randomized traffic
      for (int i = 0; i < 4000; i++) begin
         s       = '0;
         s.rsn   = ($urandom_range(0, 59) != 0);
         s.idv   = $urandom_range(0, 3) != 0;
         s.sa    = RS'($urandom_range(0, 3));
         s.sb    = RS'($urandom_range(0, 3));
         s.exv   = $urandom_range(0, 1);
         s.exwe  = $urandom_range(0, 1);
         s.exwa  = RS'($urandom_range(0, 3));
         s.memv  = $urandom_range(0, 1);
         s.memwe = $urandom_range(0, 1);
         s.memwa = RS'($urandom_range(0, 3));
         s.br    = $urandom_range(0, 7) == 0;
         s.busy  = $urandom_range(0, 5) == 0;
         s.fin   = $urandom_range(0, 19) == 0;
         step();
      end
      idle(1);

      for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
      @(negedge clk);
      #1;
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain pending=%0d want=0", exp_q.size());
      end
`ifdef SEGRE_CTRL_PERF_EN
      checks++;
      if (stall_cycles_o !== 32'(m_stall)) begin
         errors++;
         $display("FAIL stall_cycles got=%0d want=%0d", stall_cycles_o, m_stall);
      end
      checks++;
      if (flush_cnt_o !== 32'(m_flush)) begin
         errors++;
         $display("FAIL flush_cnt got=%0d want=%0d", flush_cnt_o, m_flush);
      end
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
